rc4_ctrl: RTL

Sequencer for the RC4 cipher core. It owns the 256x8 three-port S-box RAM (port 1 read-only, port 2 write-only, port 3 read/write, one shared write enable). It runs the RAM identity init, then the 256-step key-scheduling algorithm (KSA), then the keystream generator (PRGA). Keystream bytes leave on a valid/ready stream that the cipher XOR stage consumes.

---
 rtl/rc4_pkg.sv | 18 +
 rtl/rc4_ctrl_if.sv | 20 ++
 rtl/rc4_key_regs.sv | 22 ++
 rtl/rc4_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 sequencer: FSM states, byte type, S-box depth.
package rc4_pkg;
   localparam int SBOX_DEPTH = 256;

   typedef logic [7:0] byte_t;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      KSA_RD,
      KSA_WR,
      PG_RD,
      PG_WR,
      PG_OUT,
      PG_HOLD,
      DONE
   } state_e;
endpackage

// File: rtl/rc4_ctrl_if.sv
// Keystream valid/ready stream between the sequencer and the XOR stage.
interface rc4_ctrl_if;
   import rc4_pkg::*;

   byte_t ks_data;
   logic  ks_valid;
   logic  ks_ready;

   modport master (
      output ks_data,
      output ks_valid,
      input  ks_ready
   );

   modport slave (
      input  ks_data,
      input  ks_valid,
      output ks_ready
   );
endinterface

// File: rtl/rc4_key_regs.sv
// Key byte register file: one write port, combinational read at kidx.
module rc4_key_regs
   import rc4_pkg::*;
#(
   parameter int KEY_MAX = 32
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(KEY_MAX)-1:0] waddr,
   input  byte_t                      wdata,
   input  logic [$clog2(KEY_MAX)-1:0] raddr,
   output byte_t                      rdata
);
   byte_t key_q [KEY_MAX];

   // Key bytes survive reset so a session can be restarted without reloading.
   always_ff @(posedge clk) begin
      if (we) key_q[waddr] <= wdata;
   end

   assign rdata = key_q[raddr];
endmodule

// File: rtl/rc4_ctrl.sv
// RC4 sequencer: S-box identity init, 256-step KSA, then PRGA keystream out.
module rc4_ctrl
   import rc4_pkg::*;
#(
   parameter int KEY_MAX = 32,
   parameter int LEN_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [$clog2(KEY_MAX):0]   key_len,
   input  logic                       key_we,
   input  logic [$clog2(KEY_MAX)-1:0] key_waddr,
   input  byte_t                      key_wdata,
   input  logic [LEN_W-1:0]           msg_len,
   rc4_ctrl_if.master                 ks,
   output logic                       busy,
   output logic                       done,
   output logic                       ram_rst_n,
   output logic                       ram_wen,
   output byte_t                      ram_raddr_1,
   output byte_t                      ram_waddr_2,
   output byte_t                      ram_wdata_2,
   output byte_t                      ram_addr_3,
   output byte_t                      ram_wdata_3,
   input  byte_t                      ram_rdata_1,
   input  byte_t                      ram_rdata_3
);
   localparam int KW = $clog2(KEY_MAX);
   localparam byte_t I_LAST = 8'(SBOX_DEPTH - 1);

   state_e state_q, state_d;
   byte_t i_q, i_d, j_q, j_d;
   byte_t si_q, si_d, sj_q, sj_d;
   byte_t ks_data_q, ks_data_d;
   logic ks_valid_q, ks_valid_d;
   logic busy_q, busy_d, done_q, done_d;
   logic [KW-1:0] kidx_q, kidx_d;
   logic [KW:0] klen_q, klen_d, klen_clamp;
   logic [LEN_W-1:0] cnt_q, cnt_d, mlen_q, mlen_d;
   byte_t key_byte, i_nxt;

   rc4_key_regs #(.KEY_MAX(KEY_MAX)) u_key (
      .clk   (clk),
      .we    (key_we && !busy_q),
      .waddr (key_waddr),
      .wdata (key_wdata),
      .raddr (kidx_q),
      .rdata (key_byte)
   );

   assign klen_clamp = (key_len == '0) ? (KW+1)'(1) :
                       (key_len > (KW+1)'(KEY_MAX)) ? (KW+1)'(KEY_MAX) :
                       key_len;
   assign i_nxt = i_q + 8'd1;

   always_comb begin
      state_d = state_q;
      i_d = i_q;
      j_d = j_q;
      si_d = si_q;
      sj_d = sj_q;
      kidx_d = kidx_q;
      klen_d = klen_q;
      cnt_d = cnt_q;
      mlen_d = mlen_q;
      ks_data_d = ks_data_q;
      ks_valid_d = ks_valid_q;
      busy_d = busy_q;
      done_d = 1'b0;
      ram_rst_n = 1'b1;
      ram_wen = 1'b0;
      ram_raddr_1 = '0;
      ram_waddr_2 = '0;
      ram_wdata_2 = '0;
      ram_addr_3 = '0;
      ram_wdata_3 = '0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               klen_d = klen_clamp;
               mlen_d = msg_len;
               busy_d = 1'b1;
               state_d = INIT;
            end
         end
         INIT: begin
            ram_rst_n = 1'b0;
            i_d = '0;
            j_d = '0;
            kidx_d = '0;
            cnt_d = '0;
            state_d = KSA_RD;
         end
         KSA_RD: begin
            ram_raddr_1 = i_q;
            si_d = ram_rdata_1;
            j_d = j_q + ram_rdata_1 + key_byte;
            state_d = KSA_WR;
         end
         KSA_WR: begin
            ram_addr_3 = j_q;
            ram_waddr_2 = i_q;
            ram_wdata_2 = ram_rdata_3;
            ram_wdata_3 = si_q;
            ram_wen = 1'b1;
            // Key index wraps by compare so no modulo divider is needed.
            kidx_d = (kidx_q == KW'(klen_q - (KW+1)'(1))) ? '0 : kidx_q + KW'(1);
            if (i_q == I_LAST) begin
               i_d = '0;
               j_d = '0;
               state_d = (mlen_q == '0) ? DONE : PG_RD;
            end else begin
               i_d = i_nxt;
               state_d = KSA_RD;
            end
         end
         PG_RD: begin
            ram_raddr_1 = i_nxt;
            i_d = i_nxt;
            si_d = ram_rdata_1;
            j_d = j_q + ram_rdata_1;
            state_d = PG_WR;
         end
         PG_WR: begin
            ram_addr_3 = j_q;
            sj_d = ram_rdata_3;
            ram_waddr_2 = i_q;
            ram_wdata_2 = ram_rdata_3;
            ram_wdata_3 = si_q;
            ram_wen = 1'b1;
            state_d = PG_OUT;
         end
         PG_OUT: begin
            ram_raddr_1 = si_q + sj_q;
            ks_data_d = ram_rdata_1;
            ks_valid_d = 1'b1;
            state_d = PG_HOLD;
         end
         PG_HOLD: begin
            if (ks.ks_ready) begin
               ks_valid_d = 1'b0;
               cnt_d = cnt_q + LEN_W'(1);
               state_d = (cnt_d == mlen_q) ? DONE : PG_RD;
            end
         end
         DONE: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q <= '0;
         j_q <= '0;
         si_q <= '0;
         sj_q <= '0;
         kidx_q <= '0;
         klen_q <= '0;
         cnt_q <= '0;
         mlen_q <= '0;
         ks_data_q <= '0;
         ks_valid_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q <= i_d;
         j_q <= j_d;
         si_q <= si_d;
         sj_q <= sj_d;
         kidx_q <= kidx_d;
         klen_q <= klen_d;
         cnt_q <= cnt_d;
         mlen_q <= mlen_d;
         ks_data_q <= ks_data_d;
         ks_valid_q <= ks_valid_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign ks.ks_data = ks_data_q;
   assign ks.ks_valid = ks_valid_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule
